// File: rtl/display_timer_pkg.sv
// Shared helpers for the display scan timer.
//   default_div()  : terminal count giving the requested scan rate
//   digit_idx_w()  : width of a digit index for n anodes (n >= 2)
//   anode_vec_t    : active-low anode vector, sized for the widest display supported
//   anode_decode() : active-low one-hot decode of a digit index
package display_timer_pkg;

    localparam int unsigned MAX_DIGITS = 16;

    typedef logic [MAX_DIGITS-1:0] anode_vec_t;

    // Terminal count for a divider producing scan_hz ticks from clk_hz.
    function automatic int unsigned default_div(input int unsigned clk_hz,
                                                input int unsigned scan_hz);
        return (clk_hz / scan_hz) - 1;
    endfunction

    // Digit index width; never less than one bit.
    function automatic int unsigned digit_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // All ones except the bit of the selected digit.
    function automatic anode_vec_t anode_decode(input int unsigned idx);
        anode_vec_t v;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            v[i] = (i != idx);
        end
        return v;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable terminal-count divider producing a registered 1-cycle tick.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   en          : count enable; counter holds while low
//   load        : load strobe, wins over en; clears the counter, suppresses the tick
//   load_val    : new terminal count (period = load_val + 1 cycles)
//   tick        : registered pulse, one cycle after the terminal count is reached
//   wrap_c      : combinational, high in the cycle the terminal count is accepted
//   ctr_next_c  : combinational, counter value after the coming edge
module tick_divider #(
    parameter int unsigned    W         = 20,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick,
    output logic         wrap_c,
    output logic [W-1:0] ctr_next_c
);

    logic [W-1:0] ctr;
    logic [W-1:0] div_reg;

    // Next counter value; a load always clears ctr, so == is sufficient.
    always_comb begin
        wrap_c     = 1'b0;
        ctr_next_c = ctr;
        if (load) begin
            ctr_next_c = '0;
        end else if (en) begin
            if (ctr == div_reg) begin
                wrap_c     = 1'b1;
                ctr_next_c = '0;
            end else begin
                ctr_next_c = ctr + W'(1);
            end
        end
    end

    // Counter, terminal count and tick registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr     <= '0;
            div_reg <= RESET_VAL;
            tick    <= 1'b0;
        end else begin
            ctr  <= ctr_next_c;
            tick <= wrap_c;
            if (load) begin
                div_reg <= load_val;
            end
        end
    end

endmodule

// File: rtl/display_scan_timer.sv
// Scan timer for multiplexed 7-segment displays: scan tick, 50% square output,
// rotating active-low anode select and a frame marker.
// Optional feature macro: SCAN_BLANKING_EN (anti-ghost blanking at the start of
// every digit slot; without it BLANK_CYCLES is ignored).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   en           : run enable
//   div_load     : 1-cycle strobe loading div_value as the terminal count
//   div_value    : new terminal count; period = div_value + 1 clocks
//   tick         : 1-cycle pulse per scan period
//   sq_out       : toggles on every tick
//   digit_idx    : currently driven digit
//   digit_sel_n  : active-low one-hot anode select
//   frame_done   : pulses with the tick on which digit_idx wraps to 0
module display_scan_timer
    import display_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_HZ      = 1_000,
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned DIV_W        = 20,
    parameter int unsigned BLANK_CYCLES = 1_000,
    localparam int unsigned IDX_W       = digit_idx_w(N_DIGITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                div_load,
    input  logic [DIV_W-1:0]    div_value,
    output logic                tick,
    output logic                sq_out,
    output logic [IDX_W-1:0]    digit_idx,
    output logic [N_DIGITS-1:0] digit_sel_n,
    output logic                frame_done
);

    localparam int unsigned DEFAULT_DIV = default_div(CLK_HZ, SCAN_HZ);

    logic             wrap_c;
    logic [DIV_W-1:0] ctr_next_c;
    logic             last_c;
    logic [IDX_W-1:0] idx_next_c;
    logic             blank_c;

    tick_divider #(
        .W         (DIV_W),
        .RESET_VAL (DIV_W'(DEFAULT_DIV))
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (div_load),
        .load_val   (div_value),
        .tick       (tick),
        .wrap_c     (wrap_c),
        .ctr_next_c (ctr_next_c)
    );

    // Digit rotation, advancing only on an accepted terminal count.
    always_comb begin
        last_c     = (digit_idx == IDX_W'(N_DIGITS - 1));
        idx_next_c = digit_idx;
        if (wrap_c) begin
            idx_next_c = last_c ? '0 : digit_idx + IDX_W'(1);
        end
    end

`ifdef SCAN_BLANKING_EN
    // Blank while the slot counter (as it will be after this edge) is still early.
    assign blank_c = (32'(ctr_next_c) < BLANK_CYCLES);
`else
    logic unused_blank_cfg;
    assign unused_blank_cfg = ^{ctr_next_c, 32'(BLANK_CYCLES)};
    assign blank_c          = 1'b0;
`endif

    // Registered rotator, square output, frame marker and anode decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            sq_out      <= 1'b0;
            digit_idx   <= '0;
            frame_done  <= 1'b0;
            digit_sel_n <= '1;
        end else begin
            frame_done <= wrap_c && last_c;
            digit_idx  <= idx_next_c;
            if (wrap_c) begin
                sq_out <= ~sq_out;
            end
            if (en && !blank_c) begin
                digit_sel_n <= N_DIGITS'(anode_decode(32'(idx_next_c)));
            end else begin
                digit_sel_n <= '1;
            end
        end
    end

endmodule
